multi_wave_dds: RTL and testbench
=================================

// Module: multi_wave_dds
// PURPOSE
//  Parametrised multi-channel DDS waveform generator; successor to the fixed 8-output, free-running-address source.
//  Each channel has its own phase accumulator, tuning word, phase offset, waveform select and enable.
//  Waveforms: sine (external 1-cycle ROM), square, triangle, sawtooth, LFM chirp.
//  Sits between the config/control logic and the DAC/modulator datapath.
// PARAMETERS
//  NCH          4   number of independent channels
//  PHASE_W      32  phase accumulator / tuning-word width
//  ADDR_W       8   sine ROM address width (top ADDR_W bits of phase)
//  DATA_W       8   sample width; unsigned, requires DATA_W <= ADDR_W
//  CHIRP_LEN_W  8   LFM sweep period = 2**CHIRP_LEN_W cycles
// PORTS
//  clk        in   1              single clock
//  rst        in   1              synchronous, active-high reset
//  cfg_valid  in   1              config request
//  cfg_ready  out  1              config accept; transfer occurs when valid&&ready
//  cfg_ch     in   8              target channel index
//  cfg_wave   in   3              0 sine, 1 square, 2 triangle, 3 sawtooth, 4 LFM; 5-7 reserved
//  cfg_fword  in   PHASE_W        tuning word (LFM: start word)
//  cfg_step   in   PHASE_W        LFM per-cycle tuning-word increment
//  cfg_poff   in   PHASE_W        phase offset
//  cfg_en     in   1              channel enable
//  cfg_clr    in   1              clear phase accumulator and LFM state on apply
//  rom_addr   out  NCH*ADDR_W     per-channel sine ROM address; ch k at [k*ADDR_W +: ADDR_W]
//  rom_q      in   NCH*DATA_W     per-channel sine ROM data; registered, 1-cycle latency
//  dout       out  NCH*DATA_W     samples; ch k at [k*DATA_W +: DATA_W]
//  dout_valid out  NCH            per-channel sample valid
//  wrap       out  NCH            1-cycle pulse, aligned with dout, on the sample after the accumulator overflows
// BEHAVIOUR
//  Reset:
//   - Clears all accumulators, config registers (wave=0, en=0), LFM state, dout, dout_valid, wrap, rom_addr.
//   - cfg_ready=0 while rst=1; cfg_ready=1 on the first cycle after rst deasserts.
//   - rst mid-operation aborts any pending config apply.
//  Config handshake:
//   - Accept cycle T: request is captured into a shadow register; cfg_ready=0 in T+1.
//   - Applied at the edge ending T+1; back-to-back requests are accepted every other cycle.
//   - cfg_ch >= NCH: request is accepted, then discarded.
//   - Apply with cfg_clr=1: acc<=0, LFM fword<=cfg_fword, LFM count<=0.
//  Phase:
//   - Enabled channel: acc <= acc + f each cycle, modulo 2**PHASE_W; overflow generates wrap.
//   - f = cfg_fword, except in LFM mode, where f = inst_f.
//   - p = acc + poff (mod 2**PHASE_W); s = p[PHASE_W-1 -: DATA_W]; rom_addr = p[PHASE_W-1 -: ADDR_W].
//  Pipeline (2 cycles, identical for all waves):
//   - Stage 1 registers rom_addr and the arithmetic sample.
//   - Stage 2 selects rom_q or the arithmetic sample into dout.
//   - dout at cycle t reflects acc at t-2.
//  Waveforms:
//   - Square: s[DATA_W-1] ? all-ones : 0.
//   - Sawtooth: s.
//   - Triangle: s[MSB] ? ~{s[DATA_W-2:0],1'b0} : {s[DATA_W-2:0],1'b0}.
//   - Sine: rom_q.
//   - LFM: rom_q with inst_f <= inst_f + step each cycle; inst_f reloads cfg_fword when the CHIRP_LEN_W-bit count wraps.
//   - Reserved codes: dout = 2**(DATA_W-1), dout_valid=1.
//  Disabled channel:
//   - acc, inst_f and the count are held.
//   - dout = 2**(DATA_W-1) and dout_valid=0, both 2 cycles after en falls.
//   - Re-enabling resumes from the held phase.
//  Config applied to a running channel:
//   - New fword/wave take effect at the next accumulation; no glitch on other channels.
// TESTING  (NCH=2, PHASE_W=16, ADDR_W=8, DATA_W=8, CHIRP_LEN_W=4)
//  1 rst=1 for 3 cycles -> dout=0, dout_valid=0, cfg_ready=0; cycle after release -> cfg_ready=1.
//  2 ch0 saw, fword=0x0100, clr, en -> dout0 = 0x00,0x01,...,0xFF,0x00; wrap0 pulses once every 256 samples.
//  3 ch1 square, fword=0x0800 -> 16 samples of 0x00 then 16 of 0xFF, repeating; ch0 unaffected.
//  4 ch0 triangle, fword=0x0100 -> s=0x7F gives 0xFE, s=0x80 gives 0xFF, s=0xFF gives 0x01.
//  5 ch0 sine + ROM model, poff=0x4000 -> rom_addr0 leads the poff=0 run by 64; dout0 = model(rom_addr0) exactly 2 cycles after the phase.
//  6 cfg_valid held 4 cycles -> cfg_ready toggles 1,0,1,0; cfg_ch=3 has no effect; rst mid-stream clears all outputs next cycle.

Source files
------------

// File: rtl/multi_wave_dds.sv
// multi_wave_dds: multi-channel DDS generator producing sine/square/triangle/saw/LFM samples per channel
module multi_wave_dds #(
  parameter int NCH = 4,
  parameter int PHASE_W = 32,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CHIRP_LEN_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [7:0]              cfg_ch,
  input  logic [2:0]              cfg_wave,
  input  logic [PHASE_W-1:0]      cfg_fword,
  input  logic [PHASE_W-1:0]      cfg_step,
  input  logic [PHASE_W-1:0]      cfg_poff,
  input  logic                    cfg_en,
  input  logic                    cfg_clr,
  output logic [NCH*ADDR_W-1:0]   rom_addr,
  input  logic [NCH*DATA_W-1:0]   rom_q,
  output logic [NCH*DATA_W-1:0]   dout,
  output logic [NCH-1:0]          dout_valid,
  output logic [NCH-1:0]          wrap
);
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};
  logic pend_q;
  logic [7:0] sh_ch_q;
  logic [2:0] sh_wave_q;
  logic [PHASE_W-1:0] sh_fword_q, sh_step_q, sh_poff_q;
  logic sh_en_q, sh_clr_q;
  assign cfg_ready = ~rst & ~pend_q;
  always_ff @(posedge clk) begin
    if (rst) pend_q <= 1'b0;
    else pend_q <= cfg_valid & cfg_ready;
  end
  always_ff @(posedge clk) begin
    if (cfg_valid && cfg_ready)
      {sh_ch_q, sh_wave_q, sh_fword_q, sh_step_q, sh_poff_q, sh_en_q, sh_clr_q} <=
        {cfg_ch, cfg_wave, cfg_fword, cfg_step, cfg_poff, cfg_en, cfg_clr};
  end
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [2:0] wave_q;
    logic [PHASE_W-1:0] fword_q, step_q, poff_q, acc_q, inst_q, f, sum;
    logic [CHIRP_LEN_W-1:0] cnt_q;
    logic en_q, wrap0_q, lfm, hit, carry;
    logic [ADDR_W-1:0] pa, ra_q;
    logic [DATA_W-1:0] s, tri_s, arith, s1_q, s2_q;
    logic r1_q, v1_q, w1_q, r2_q, v2_q, w2_q;
    always_comb begin
      hit = pend_q && sh_ch_q == 8'(c);
      lfm = wave_q == 3'd4;
      f = lfm ? inst_q : fword_q;
      {carry, sum} = {1'b0, acc_q} + {1'b0, f};
      pa = ADDR_W'((acc_q + poff_q) >> (PHASE_W - ADDR_W));
      s = DATA_W'(pa >> (ADDR_W - DATA_W));
      tri_s = s[DATA_W-1] ? ~{s[DATA_W-2:0], 1'b0} : {s[DATA_W-2:0], 1'b0};
      arith = !en_q || wave_q > 3'd4 ? MID :
              wave_q == 3'd1 ? {DATA_W{s[DATA_W-1]}} :
              wave_q == 3'd2 ? tri_s : s;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        {wave_q, en_q, fword_q, step_q, poff_q, acc_q, inst_q, cnt_q, wrap0_q} <= '0;
        {ra_q, s1_q, r1_q, v1_q, w1_q, s2_q, r2_q, v2_q, w2_q} <= '0;
      end else begin
        wrap0_q <= en_q & carry;
        if (en_q) acc_q <= sum;
        if (en_q && lfm) begin
          inst_q <= &cnt_q ? fword_q : inst_q + step_q;
          cnt_q <= cnt_q + CHIRP_LEN_W'(1);
        end
        if (hit) begin
          {wave_q, fword_q, step_q, poff_q, en_q} <= {sh_wave_q, sh_fword_q, sh_step_q, sh_poff_q, sh_en_q};
          if (sh_clr_q) begin
            acc_q <= '0;
            inst_q <= sh_fword_q;
            cnt_q <= '0;
            wrap0_q <= 1'b0;
          end
        end
        ra_q <= pa;
        s1_q <= arith;
        r1_q <= en_q && (wave_q == 3'd0 || lfm);
        v1_q <= en_q;
        w1_q <= en_q & wrap0_q;
        {s2_q, r2_q, v2_q, w2_q} <= {s1_q, r1_q, v1_q, w1_q};
      end
    end
    assign rom_addr[c*ADDR_W +: ADDR_W] = ra_q;
    assign dout[c*DATA_W +: DATA_W] = r2_q ? rom_q[c*DATA_W +: DATA_W] : s2_q;
    assign dout_valid[c] = v2_q;
    assign wrap[c] = w2_q;
  end
endmodule

// File: tb/tb_multi_wave_dds.sv
// tb_multi_wave_dds: scoreboard bench comparing the DDS against a cycle-level arithmetic reference model
module tb_multi_wave_dds;
  localparam int NCH = 2, PW = 16, AW = 8, DW = 8, CW = 4;
  typedef struct packed {
    logic [NCH-1:0][DW-1:0] d;
    logic [NCH-1:0] v;
    logic [NCH-1:0] w;
  } exp_t;
  typedef struct packed {
    logic [7:0] ch;
    logic [2:0] wave;
    logic [PW-1:0] fword, step, poff;
    logic en, clr;
  } cfg_t;
  logic clk = 0, rst = 1, cfg_valid = 0, cfg_en = 0, cfg_clr = 0;
  logic cfg_ready;
  logic [7:0] cfg_ch = 0;
  logic [2:0] cfg_wave = 0;
  logic [PW-1:0] cfg_fword = 0, cfg_step = 0, cfg_poff = 0;
  logic [NCH*AW-1:0] rom_addr;
  logic [NCH*DW-1:0] rom_q = 0, dout;
  logic [NCH-1:0] dout_valid, wrap;
  logic [7:0] rom [256];
  int errors = 0, checks = 0;
  exp_t sbq[$];
  exp_t e, e_mon;
  cfg_t sh;
  bit armed = 0, m_pend = 0, take;
  logic [NCH*AW-1:0] exp_ra;
  logic [2:0] m_wave [NCH];
  logic [PW-1:0] m_f [NCH], m_step [NCH], m_poff [NCH], m_acc [NCH], m_inst [NCH];
  int m_cnt [NCH];
  bit m_en [NCH], m_wf [NCH];
  int ph, s, sum, tc;
  always #5 clk = ~clk;
  multi_wave_dds #(.NCH(NCH), .PHASE_W(PW), .ADDR_W(AW), .DATA_W(DW), .CHIRP_LEN_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_wave(cfg_wave), .cfg_fword(cfg_fword), .cfg_step(cfg_step), .cfg_poff(cfg_poff),
    .cfg_en(cfg_en), .cfg_clr(cfg_clr), .rom_addr(rom_addr), .rom_q(rom_q), .dout(dout),
    .dout_valid(dout_valid), .wrap(wrap)
  );
  always @(posedge clk)
    for (int k = 0; k < NCH; k++) rom_q[k*DW +: DW] <= rom[rom_addr[k*AW +: AW]];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      armed = 1;
      sbq.delete();
      sbq.push_back('0);
      sbq.push_back('0);
      m_pend = 0;
      exp_ra = '0;
      for (int c = 0; c < NCH; c++) begin
        m_wave[c] = 0; m_f[c] = 0; m_step[c] = 0; m_poff[c] = 0;
        m_acc[c] = 0; m_inst[c] = 0; m_cnt[c] = 0; m_en[c] = 0; m_wf[c] = 0;
      end
    end else begin
      take = cfg_valid && !m_pend;
      for (int c = 0; c < NCH; c++) begin
        ph = (int'(m_acc[c]) + int'(m_poff[c])) % (1 << PW);
        s = ph >> (PW - DW);
        exp_ra[c*AW +: AW] = AW'(ph >> (PW - AW));
        e.w[c] = m_wf[c] && m_en[c];
        e.v[c] = m_en[c];
        if (!m_en[c]) e.d[c] = 8'h80;
        else case (m_wave[c])
          3'd0, 3'd4: e.d[c] = rom[s];
          3'd1: e.d[c] = s >= 128 ? 8'hFF : 8'h00;
          3'd2: e.d[c] = DW'(s < 128 ? 2 * s : 511 - 2 * s);
          3'd3: e.d[c] = DW'(s);
          default: e.d[c] = 8'h80;
        endcase
      end
      sbq.push_back(e);
      for (int c = 0; c < NCH; c++) begin
        if (m_en[c]) begin
          sum = int'(m_acc[c]) + int'(m_wave[c] == 3'd4 ? m_inst[c] : m_f[c]);
          m_wf[c] = sum >= (1 << PW);
          m_acc[c] = PW'(sum);
          if (m_wave[c] == 3'd4) begin
            if (m_cnt[c] == (1 << CW) - 1) begin
              m_inst[c] = m_f[c];
              m_cnt[c] = 0;
            end else begin
              m_inst[c] = m_inst[c] + m_step[c];
              m_cnt[c]++;
            end
          end
        end else m_wf[c] = 0;
      end
      if (m_pend && sh.ch < NCH) begin
        tc = int'(sh.ch);
        m_wave[tc] = sh.wave; m_f[tc] = sh.fword; m_step[tc] = sh.step;
        m_poff[tc] = sh.poff; m_en[tc] = sh.en;
        if (sh.clr) begin
          m_acc[tc] = 0; m_inst[tc] = sh.fword; m_cnt[tc] = 0; m_wf[tc] = 0;
        end
      end
      m_pend = take;
      if (take) sh = {cfg_ch, cfg_wave, cfg_fword, cfg_step, cfg_poff, cfg_en, cfg_clr};
    end
  end
  always @(negedge clk) begin
    if (armed) begin
      chk("cfg_ready", 32'(cfg_ready), 32'(!rst && !m_pend));
      chk("rom_addr", 32'(rom_addr), 32'(exp_ra));
      if (sbq.size() > 1) begin
        e_mon = sbq.pop_front();
        for (int c = 0; c < NCH; c++) begin
          chk($sformatf("dout%0d", c), 32'(dout[c*DW +: DW]), 32'(e_mon.d[c]));
          chk($sformatf("dout_valid%0d", c), 32'(dout_valid[c]), 32'(e_mon.v[c]));
          chk($sformatf("wrap%0d", c), 32'(wrap[c]), 32'(e_mon.w[c]));
        end
      end
    end
  end
  task automatic cfg(input int ch, input int wave, input int fword, input int step,
                     input int poff, input int en, input int clr);
    int n = 0;
    @(posedge clk);
    #1;
    cfg_valid = 1; cfg_ch = 8'(ch); cfg_wave = 3'(wave); cfg_fword = PW'(fword);
    cfg_step = PW'(step); cfg_poff = PW'(poff); cfg_en = en != 0; cfg_clr = clr != 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cfg_ready && n < 20);
    if (!cfg_ready) chk("cfg_timeout", 32'(cfg_ready), 32'd1);
    @(posedge clk);
    #1 cfg_valid = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("ready_after_rst", 32'(cfg_ready), 32'd1);
    cfg(0, 3, 'h0100, 0, 0, 1, 1);
    idle(600);
    cfg(1, 1, 'h0800, 0, 0, 1, 1);
    idle(100);
    cfg(0, 2, 'h0100, 0, 0, 1, 1);
    idle(300);
    cfg(0, 0, 'h0100, 0, 'h4000, 1, 1);
    idle(300);
    cfg(0, 0, 'h0100, 0, 'h4000, 0, 0);
    idle(20);
    cfg(0, 0, 'h0100, 0, 'h4000, 1, 0);
    idle(20);
    cfg(1, 4, 'h0100, 'h0040, 0, 1, 1);
    idle(100);
    cfg(1, 6, 'h0100, 0, 0, 1, 0);
    idle(10);
    idle(3);
    @(posedge clk);
    #1;
    cfg_valid = 1; cfg_ch = 8'd3; cfg_wave = 3'd1; cfg_fword = 16'h1234; cfg_en = 1; cfg_clr = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("hold_ready%0d", i), 32'(cfg_ready), 32'((i % 2) == 0));
    end
    @(posedge clk);
    #1 cfg_valid = 0;
    idle(10);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_dout", 32'(dout), 32'd0);
    chk("midrst_valid", 32'(dout_valid), 32'd0);
    chk("midrst_wrap", 32'(wrap), 32'd0);
    chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 40; i++) begin
      cfg($urandom_range(0, 2), $urandom_range(0, 7), $urandom_range(0, 16'hFFFF),
          $urandom_range(0, 16'hFFFF), $urandom_range(0, 16'hFFFF),
          $urandom_range(0, 3) != 0, $urandom_range(0, 1));
      idle($urandom_range(0, 30));
    end
    idle(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
